// File: rtl/i2c_bus_timing_checker_pkg.sv
// ---------------------------------------------------------------------------
// i2c_tchk_pkg
// Shared constants for the I2C bus timing checker:
//   E_ANY / E_RISE    edge-qualification codes for the E1/E2 parameters
//   TCHK_W_DEFAULT    default width of counter, limit and statistics
//   MODE_EE/EL/LE     E1/E2 pairs, plus one alias per I2C timing rule
// ---------------------------------------------------------------------------
package i2c_tchk_pkg;

    localparam bit E_ANY  = 1'b0;   // any edge: s ^ s_q
    localparam bit E_RISE = 1'b1;   // rising edge only: s & ~s_q

    localparam int TCHK_W_DEFAULT = 16;

    typedef struct packed {
        logic e1;   // qualification of the reference signal s1
        logic e2;   // qualification of the checked signal s2
    } tchk_mode_t;

    localparam tchk_mode_t MODE_EE = '{e1: E_RISE, e2: E_RISE};
    localparam tchk_mode_t MODE_EL = '{e1: E_RISE, e2: E_ANY};
    localparam tchk_mode_t MODE_LE = '{e1: E_ANY,  e2: E_RISE};

    // Falling edges are checked by inverting the input at the instance.
    localparam tchk_mode_t RULE_THD_STA = MODE_EE;  // s1 = ~sda,   s2 = ~scl
    localparam tchk_mode_t RULE_TLOW    = MODE_LE;  // s1 = s2 = scl
    localparam tchk_mode_t RULE_THD_DAT = MODE_EL;  // s1 = ~scl,   s2 = sda
    localparam tchk_mode_t RULE_TSU_DAT = MODE_LE;  // s1 = sda,    s2 = scl
    localparam tchk_mode_t RULE_THIGH   = MODE_EE;  // s1 = scl,    s2 = ~scl
    localparam tchk_mode_t RULE_TSU_STA = MODE_EE;  // s1 = scl,    s2 = ~sda
    localparam tchk_mode_t RULE_TSU_STO = MODE_EE;  // s1 = scl,    s2 = sda

endpackage : i2c_tchk_pkg

// File: rtl/i2c_bus_timing_checker_if.sv
// ---------------------------------------------------------------------------
// i2c_bus_timing_checker_if
// Bundle of the monitored signals and the checker results.
//   s1, s2   reference / checked bus signals
//   lim      minimum legal interval in clk cycles
//   vio      one-cycle violation pulse
//   delta    interval measured at the most recent s2 event
//   vio_cnt  saturating violation count
// master: stimulus side (drives s1/s2/lim); slave: the checker.
// ---------------------------------------------------------------------------
interface i2c_bus_timing_checker_if #(
    parameter int W = 16
) ();
    logic         s1;
    logic         s2;
    logic [W-1:0] lim;
    logic         vio;
    logic [W-1:0] delta;
    logic [W-1:0] vio_cnt;

    modport master (
        output s1, s2, lim,
        input  vio, delta, vio_cnt
    );

    modport slave (
        input  s1, s2, lim,
        output vio, delta, vio_cnt
    );
endinterface : i2c_bus_timing_checker_if

// File: rtl/i2c_bus_timing_checker_edge.sv
// ---------------------------------------------------------------------------
// i2c_tchk_edge
// Edge qualifier for one monitored signal.
//   clk   sampling clock
//   rst   asynchronous active-high reset
//   s_i   monitored signal (already synchronous to clk)
//   ev_o  event strobe, high in the cycle the qualifying edge is sampled
// MODE = E_RISE flags rising edges only, MODE = E_ANY flags any change.
// ---------------------------------------------------------------------------
module i2c_tchk_edge
    import i2c_tchk_pkg::*;
#(
    parameter bit MODE = E_RISE
) (
    input  logic clk,
    input  logic rst,
    input  logic s_i,
    output logic ev_o
);

    logic s_q;

    // Reset loads the live input so that releasing reset never looks like
    // an edge, whatever level the bus is sitting at.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q <= s_i;
        end else begin
            s_q <= s_i;
        end
    end

    generate
        if (MODE == E_RISE) begin : g_rise
            assign ev_o = s_i & ~s_q;
        end else begin : g_any
            assign ev_o = s_i ^ s_q;
        end
    endgenerate

endmodule : i2c_tchk_edge

// File: rtl/i2c_bus_timing_checker.sv
// ---------------------------------------------------------------------------
// i2c_bus_timing_checker
// Counts clk cycles from a qualifying s1 event to the next qualifying s2
// event and flags an interval shorter than lim.
//   clk       sampling clock
//   rst       asynchronous active-high reset
//   mon       slave modport: s1, s2, lim in; vio, delta, vio_cnt out
// Parameters: E1_MODE / E2_MODE edge qualification, W counter width.
// ---------------------------------------------------------------------------
module i2c_bus_timing_checker
    import i2c_tchk_pkg::*;
#(
    parameter bit E1_MODE = E_RISE,
    parameter bit E2_MODE = E_RISE,
    parameter int W       = TCHK_W_DEFAULT
) (
    input  logic                            clk,
    input  logic                            rst,
    i2c_bus_timing_checker_if.slave         mon
);

    localparam logic [W-1:0] CNT_MAX = '1;
    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam bit   [1:0]   MODES   = {E2_MODE, E1_MODE};

    logic [1:0] sig_vec;
    logic [1:0] ev_vec;     // [0] = ev1 (start), [1] = ev2 (check)

    assign sig_vec = {mon.s2, mon.s1};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_edge
            i2c_tchk_edge #(
                .MODE (MODES[gi])
            ) u_edge (
                .clk  (clk),
                .rst  (rst),
                .s_i  (sig_vec[gi]),
                .ev_o (ev_vec[gi])
            );
        end
    endgenerate

    logic [W-1:0] cnt_q,     cnt_d;
    logic [W-1:0] delta_q,   delta_d;
    logic         vio_q,     vio_d;
    logic [W-1:0] vio_cnt_q, vio_cnt_d;

    always_comb begin
        cnt_d     = cnt_q;
        delta_d   = delta_q;
        vio_d     = 1'b0;
        vio_cnt_d = vio_cnt_q;

        // Interval counter: restart on ev1, otherwise count up and stick at
        // the maximum, which doubles as "no origin seen yet".
        if (ev_vec[0]) begin
            cnt_d = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end

        // The check always uses the pre-update count, so a simultaneous ev1
        // is judged against the previous origin. A saturated count can never
        // be below lim, so it never flags.
        if (ev_vec[1]) begin
            delta_d = cnt_q;
            if (cnt_q < mon.lim) begin
                vio_d = 1'b1;
                if (vio_cnt_q != CNT_MAX) begin
                    vio_cnt_d = vio_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= CNT_MAX;
            delta_q   <= '0;
            vio_q     <= 1'b0;
            vio_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            delta_q   <= delta_d;
            vio_q     <= vio_d;
            vio_cnt_q <= vio_cnt_d;
        end
    end

    assign mon.vio     = vio_q;
    assign mon.delta   = delta_q;
    assign mon.vio_cnt = vio_cnt_q;

endmodule : i2c_bus_timing_checker

// File: tb/tb_i2c_bus_timing_checker.sv
// ---------------------------------------------------------------------------
// tb_i2c_bus_timing_checker
// Directed bench for four checker instances:
//   u_ee  RISE/RISE, W=16, lim=10
//   u_le  ANY/RISE,  W=16, lim=5, s1 = s2 = scl
//   u_el  RISE/ANY,  W=16, lim=0
//   u_sat ANY/ANY,   W=4,  lim=15, s1 = s2 (violation counter saturation)
// ---------------------------------------------------------------------------
module tb_i2c_bus_timing_checker;
    import i2c_tchk_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    i2c_bus_timing_checker_if #(.W(16)) ee_if ();
    i2c_bus_timing_checker_if #(.W(16)) le_if ();
    i2c_bus_timing_checker_if #(.W(16)) el_if ();
    i2c_bus_timing_checker_if #(.W(4))  sat_if ();

    i2c_bus_timing_checker #(.E1_MODE(E_RISE), .E2_MODE(E_RISE), .W(16)) u_ee (
        .clk (clk), .rst (rst), .mon (ee_if.slave));
    i2c_bus_timing_checker #(.E1_MODE(E_ANY),  .E2_MODE(E_RISE), .W(16)) u_le (
        .clk (clk), .rst (rst), .mon (le_if.slave));
    i2c_bus_timing_checker #(.E1_MODE(E_RISE), .E2_MODE(E_ANY),  .W(16)) u_el (
        .clk (clk), .rst (rst), .mon (el_if.slave));
    i2c_bus_timing_checker #(.E1_MODE(E_ANY),  .E2_MODE(E_ANY),  .W(4))  u_sat (
        .clk (clk), .rst (rst), .mon (sat_if.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // s1 rises (sampled at edge P0), s2 rises sampled at edge Pk.
    task automatic ee_run(input int k);
        ee_if.s1 = 1'b1;
        tick();
        repeat (k - 1) tick();
        ee_if.s2 = 1'b1;
        tick();
    endtask

    // scl low for n sampled cycles, then rises.
    task automatic le_low(input int n);
        le_if.s1 = 1'b0; le_if.s2 = 1'b0;
        tick();
        repeat (n - 1) tick();
        le_if.s1 = 1'b1; le_if.s2 = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1;
        ee_if.s1  = 1'b1; ee_if.s2  = 1'b1; ee_if.lim  = 16'd10;
        le_if.s1  = 1'b1; le_if.s2  = 1'b1; le_if.lim  = 16'd5;
        el_if.s1  = 1'b0; el_if.s2  = 1'b0; el_if.lim  = 16'd0;
        sat_if.s1 = 1'b0; sat_if.s2 = 1'b0; sat_if.lim = 4'd15;
        repeat (2) tick();

        chk("rst_vio",     32'(ee_if.vio),     32'd0);
        chk("rst_delta",   32'(ee_if.delta),   32'd0);
        chk("rst_viocnt",  32'(ee_if.vio_cnt), 32'd0);

        rst = 1'b0;
        tick();

        // ev2 with no ev1 since reset: saturated count, no violation
        ee_if.s2 = 1'b0; tick();
        ee_if.s2 = 1'b1; tick();
        chk("noorg_delta",  32'(ee_if.delta),   32'd65535);
        chk("noorg_vio",    32'(ee_if.vio),     32'd0);
        chk("noorg_viocnt", 32'(ee_if.vio_cnt), 32'd0);

        // RISE/RISE, lim = 10
        ee_if.s1 = 1'b0; ee_if.s2 = 1'b0; tick();
        ee_run(4);
        chk("ee4_delta",  32'(ee_if.delta),   32'd4);
        chk("ee4_vio",    32'(ee_if.vio),     32'd1);
        chk("ee4_viocnt", 32'(ee_if.vio_cnt), 32'd1);
        tick();
        chk("ee4_pulse",  32'(ee_if.vio),     32'd0);

        ee_if.s1 = 1'b0; ee_if.s2 = 1'b0; tick();
        ee_run(10);
        chk("ee10_delta",  32'(ee_if.delta),   32'd10);
        chk("ee10_vio",    32'(ee_if.vio),     32'd0);
        chk("ee10_viocnt", 32'(ee_if.vio_cnt), 32'd1);

        ee_if.s1 = 1'b0; ee_if.s2 = 1'b0; tick();
        ee_run(9);
        chk("ee9_delta",  32'(ee_if.delta),   32'd9);
        chk("ee9_vio",    32'(ee_if.vio),     32'd1);
        chk("ee9_viocnt", 32'(ee_if.vio_cnt), 32'd2);

        // ANY/RISE on scl, lim = 5: low time measurement
        le_low(3);
        chk("le3_delta", 32'(le_if.delta), 32'd3);
        chk("le3_vio",   32'(le_if.vio),   32'd1);
        tick();
        chk("le3_pulse", 32'(le_if.vio),   32'd0);
        le_low(6);
        chk("le6_delta", 32'(le_if.delta), 32'd6);
        chk("le6_vio",   32'(le_if.vio),   32'd0);
        tick();
        le_low(5);
        chk("le5_delta", 32'(le_if.delta), 32'd5);
        chk("le5_vio",   32'(le_if.vio),   32'd0);
        tick();
        le_low(4);
        chk("le4_delta",  32'(le_if.delta),   32'd4);
        chk("le4_vio",    32'(le_if.vio),     32'd1);
        chk("le4_viocnt", 32'(le_if.vio_cnt), 32'd2);

        // RISE/ANY, lim = 0: back-to-back checks against one origin
        el_if.s1 = 1'b1; tick();
        tick();
        el_if.s2 = 1'b1; tick();
        chk("el2_delta", 32'(el_if.delta), 32'd2);
        chk("el2_vio",   32'(el_if.vio),   32'd0);
        el_if.s2 = 1'b0; tick();
        chk("el3_delta", 32'(el_if.delta), 32'd3);
        chk("el3_vio",   32'(el_if.vio),   32'd0);
        el_if.s2 = 1'b1; tick();
        chk("el4_delta",  32'(el_if.delta),   32'd4);
        chk("el4_viocnt", 32'(el_if.vio_cnt), 32'd0);

        // W=4, lim = 15: saturated count never flags, then counter saturation
        sat_if.s1 = 1'b1; sat_if.s2 = 1'b1; tick();
        chk("sat_first_delta", 32'(sat_if.delta), 32'd15);
        chk("sat_first_vio",   32'(sat_if.vio),   32'd0);
        for (int i = 0; i < 14; i++) begin
            sat_if.s1 = ~sat_if.s1; sat_if.s2 = sat_if.s1; tick();
        end
        chk("sat_cnt14", 32'(sat_if.vio_cnt), 32'd14);
        chk("sat_delta", 32'(sat_if.delta),   32'd1);
        for (int i = 0; i < 2; i++) begin
            sat_if.s1 = ~sat_if.s1; sat_if.s2 = sat_if.s1; tick();
        end
        chk("sat_cnt16", 32'(sat_if.vio_cnt), 32'd15);
        for (int i = 0; i < 4; i++) begin
            sat_if.s1 = ~sat_if.s1; sat_if.s2 = sat_if.s1; tick();
        end
        chk("sat_hold", 32'(sat_if.vio_cnt), 32'd15);
        chk("sat_vio",  32'(sat_if.vio),     32'd1);

        // Reset in the middle of an interval (cnt = 3)
        ee_if.s1 = 1'b0; ee_if.s2 = 1'b0; tick();
        ee_if.s1 = 1'b1; tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_delta",  32'(ee_if.delta),    32'd0);
        chk("mid_rst_viocnt", 32'(ee_if.vio_cnt),  32'd0);
        chk("mid_rst_sat",    32'(sat_if.vio_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        ee_if.s2 = 1'b1; tick();
        chk("post_rst_delta",  32'(ee_if.delta),   32'd65535);
        chk("post_rst_vio",    32'(ee_if.vio),     32'd0);
        chk("post_rst_viocnt", 32'(ee_if.vio_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_i2c_bus_timing_checker
